mfp_uart_transmitter: RTL and testbench
=======================================

MFP_UART_TRANSMITTER -- requirements
Module: mfp_uart_transmitter

Interface
REQ-001 Parameters SHALL be, one per line:
- clock_frequency, 50000000, clock frequency in Hz.
- baud_rate, 9600, line rate in symbols per second.
- clock_cycles_in_symbol, clock_frequency / baud_rate, clock cycles per transmitted bit; legal range >= 2.
- fifo_depth, 4, transmit FIFO entries; must be a power of 2 and >= 2.

REQ-002 Ports SHALL be, one per line:
- clock  input  1  the single clock; all logic on its rising edge.
- reset  input  1  reset, synchronous and active-high.
- byte_data  input  8  byte to transmit.
- byte_valid  input  1  byte_data is offered this cycle.
- byte_ready  output  1  FIFO can accept a byte this cycle.
- tx  output  1  serial line, idle high, driven from a flop.
- busy  output  1  a frame is on the line or the FIFO is non-empty.

Function
REQ-003 Frame format SHALL be 8N1: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
REQ-004 Each bit SHALL hold tx constant for exactly clock_cycles_in_symbol cycles; a frame SHALL last 10 * clock_cycles_in_symbol cycles.
REQ-005 Handshake: a byte SHALL be accepted on a rising edge where byte_valid=1 and byte_ready=1; byte_data SHALL be captured on that edge.
REQ-006 byte_ready SHALL be 1 exactly when FIFO occupancy < fifo_depth; byte_valid while byte_ready=0 SHALL be ignored without data loss or corruption.
REQ-007 The FIFO SHALL preserve byte order and use wrap-around pointers; an occupancy counter SHALL be log2(fifo_depth)+1 bits wide.
REQ-008 A simultaneous push and pop on the same edge SHALL leave occupancy unchanged and SHALL transmit both bytes in order.
REQ-009 FSM states SHALL be IDLE, START, DATA, STOP; a bit counter (0..7) SHALL index DATA, and a baud counter SHALL count symbol cycles.
REQ-010 IDLE -> START: when the FIFO is non-empty, pop the head into the shift register and drive tx=0 on the same edge.
REQ-011 START -> DATA, DATA bit n -> bit n+1, DATA bit 7 -> STOP, and STOP -> next state SHALL each occur when the baud counter expires.
REQ-012 On STOP expiry, if the FIFO is non-empty, the FSM SHALL go directly to START and pop; no idle cycles between frames.
REQ-013 On STOP expiry with the FIFO empty, the FSM SHALL go to IDLE with tx=1.
REQ-014 Latency: with the FSM in IDLE and the FIFO empty, a byte accepted at edge E SHALL produce tx=0 from edge E+1.
REQ-015 busy SHALL be 1 whenever the state is not IDLE or occupancy > 0, and SHALL be registered-consistent with tx, with no combinational path from byte_valid.
REQ-016 byte_ready SHALL NOT depend combinationally on byte_valid.

Reset
REQ-017 On any rising edge with reset=1, the block SHALL set state=IDLE, tx=1, busy=0, byte_ready=1, FIFO empty, and clear all counters.
REQ-018 Reset asserted mid-frame SHALL abort the frame: tx=1 from that edge; bytes queued before reset SHALL be discarded and never transmitted.
REQ-019 No byte SHALL be accepted on an edge where reset=1.

Verification (clock_frequency=100, baud_rate=10, so 10 cycles/symbol; fifo_depth=4)
REQ-020 Single byte: push 0xA5 while idle -> tx=0 from E+1 for 10 cycles, then 1,0,1,0,0,1,0,1 at 10 cycles each, then 1 for 10 cycles; busy falls at E+101.
REQ-021 Back-to-back: push 0x00 and 0xFF on consecutive cycles -> two 100-cycle frames with no gap; the second start bit follows the first stop bit immediately.
REQ-022 Full FIFO: while the first frame transmits, push 5 more bytes -> byte_ready=0 after 4 are queued; the 5th is held until a pop, and all 6 bytes are transmitted in order.
REQ-023 Simultaneous push/pop: push exactly on the STOP-expiry edge with 1 entry queued -> occupancy stays 1 and the order is preserved.
REQ-024 Reset mid-frame: assert reset during DATA bit 3 with 2 bytes queued -> tx=1, busy=0, byte_ready=1 next edge; no further frames appear after reset is released.

Source files
------------

// File: rtl/mfp_uart_transmitter.sv
// 8N1 UART transmitter fed by a small power-of-two byte FIFO.
// Single rising-edge clock domain with a synchronous, active-high reset.
module mfp_uart_transmitter #(
    parameter int unsigned clock_frequency        = 50000000,
    parameter int unsigned baud_rate              = 9600,
    parameter int unsigned clock_cycles_in_symbol = clock_frequency / baud_rate,
    parameter int unsigned fifo_depth             = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] byte_data,
    input  logic       byte_valid,
    output logic       byte_ready,
    output logic       tx,
    output logic       busy
);

    localparam int unsigned PtrW  = (fifo_depth > 2) ? $clog2(fifo_depth) : 1;
    localparam int unsigned CntW  = PtrW + 1;
    localparam int unsigned BaudW = (clock_cycles_in_symbol > 2) ?
                                    $clog2(clock_cycles_in_symbol) : 1;

    localparam logic [CntW-1:0]  DepthVal = CntW'(fifo_depth);
    localparam logic [BaudW-1:0] BaudLast = BaudW'(clock_cycles_in_symbol - 1);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_e;

    // FIFO storage and bookkeeping
    logic [7:0]      mem_q [fifo_depth];
    logic [7:0]      mem_d [fifo_depth];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;

    // Serialiser state
    state_e           state_q, state_d;
    logic [BaudW-1:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;

    logic       push;
    logic       pop;
    logic       fifo_empty;
    logic       baud_done;
    logic [7:0] head;

    // byte_ready is a pure function of registered occupancy, never of byte_valid.
    assign byte_ready = (count_q < DepthVal);
    assign fifo_empty = (count_q == '0);
    assign push       = byte_valid && byte_ready;
    assign head       = mem_q[rd_ptr_q];
    assign baud_done  = (baud_cnt_q == BaudLast);

    assign tx   = tx_q;
    assign busy = busy_q;

    // FIFO next state
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push) begin
            mem_d[wr_ptr_q] = byte_data;
            wr_ptr_d        = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    // Frame FSM: the shift register shifts right so the next data bit is always at [1]/[0].
    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q + BaudW'(1);
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        pop        = 1'b0;

        unique case (state_q)
            StIdle: begin
                baud_cnt_d = '0;
                tx_d       = 1'b1;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = head;
                    tx_d    = 1'b0;
                    state_d = StStart;
                end
            end

            StStart: begin
                if (baud_done) begin
                    baud_cnt_d = '0;
                    bit_cnt_d  = '0;
                    tx_d       = shift_q[0];
                    state_d    = StData;
                end
            end

            StData: begin
                if (baud_done) begin
                    baud_cnt_d = '0;
                    if (bit_cnt_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = StStop;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                        tx_d      = shift_q[1];
                    end
                end
            end

            StStop: begin
                if (baud_done) begin
                    baud_cnt_d = '0;
                    if (!fifo_empty) begin
                        // Chain straight into the next start bit with no idle gap.
                        pop     = 1'b1;
                        shift_d = head;
                        tx_d    = 1'b0;
                        state_d = StStart;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = StIdle;
                    end
                end
            end

            default: begin
                baud_cnt_d = '0;
                tx_d       = 1'b1;
                state_d    = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle) || (count_d != '0);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StIdle;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Storage needs no reset: emptiness is tracked by count_q alone.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_mfp_uart_transmitter.sv
// Directed bench for mfp_uart_transmitter at 10 clocks per symbol, depth-4 FIFO.
// A bench-side receiver decodes frames from tx for order and spacing comparisons.
module tb_mfp_uart_transmitter;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] byte_data = 8'h00;
    logic       byte_valid = 1'b0;
    logic       byte_ready;
    logic       tx;
    logic       busy;

    int          checks = 0;
    int          failures = 0;
    int unsigned cyc = 0;

    logic [7:0]  rx_data [$];
    int unsigned rx_start [$];
    logic        rx_stop [$];

    mfp_uart_transmitter #(
        .clock_frequency(100),
        .baud_rate(10),
        .fifo_depth(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .byte_data(byte_data),
        .byte_valid(byte_valid),
        .byte_ready(byte_ready),
        .tx(tx),
        .busy(busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Receiver: samples mid-bit on the falling edge, start time is the edge tx first went low.
    initial begin
        logic        active;
        int          off;
        int unsigned t0;
        logic [7:0]  sh;
        active = 1'b0;
        off = 0;
        t0 = 0;
        sh = '0;
        forever begin
            @(negedge clock);
            if (reset) begin
                active = 1'b0;
            end else if (!active) begin
                if (tx === 1'b0) begin
                    active = 1'b1;
                    off = 0;
                    t0 = cyc;
                end
            end else begin
                off++;
                if (off >= 15 && off <= 85 && (off % 10) == 5) sh = {tx, sh[7:1]};
                if (off == 95) begin
                    rx_data.push_back(sh);
                    rx_start.push_back(t0);
                    rx_stop.push_back(tx);
                end
                if (off == 99) active = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        byte_data = b;
        byte_valid = 1'b1;
        step();
        byte_valid = 1'b0;
    endtask

    task automatic clear_rx();
        rx_data.delete();
        rx_start.delete();
        rx_stop.delete();
    endtask

    task automatic test_reset();
        int bad;
        reset = 1'b1;
        byte_data = 8'h5A;
        byte_valid = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        byte_valid = 1'b0;
        checks++;
        if (tx !== 1'b1) begin
            failures++; $display("FAIL reset_tx got %b want 1", tx);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++; $display("FAIL reset_busy got %b want 0", busy);
        end
        checks++;
        if (byte_ready !== 1'b1) begin
            failures++; $display("FAIL reset_ready got %b want 1", byte_ready);
        end
        bad = 0;
        repeat (20) begin
            step();
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++; $display("FAIL reset_no_accept got %0d bad cycles want 0", bad);
        end
    endtask

    task automatic test_single_byte();
        logic [9:0]  exp_bits;
        int unsigned e;
        clear_rx();
        exp_bits = {1'b1, 8'hA5, 1'b0};
        push(8'hA5);
        e = cyc;
        checks++;
        if (busy !== 1'b1 || tx !== 1'b1) begin
            failures++; $display("FAIL single_edge_e got busy=%b tx=%b want busy=1 tx=1", busy, tx);
        end
        for (int k = 1; k <= 100; k++) begin
            step();
            checks++;
            if (tx !== exp_bits[(k-1)/10]) begin
                failures++;
                $display("FAIL single_tx at E+%0d got %b want %b", k, tx, exp_bits[(k-1)/10]);
            end
        end
        checks++;
        if (busy !== 1'b1) begin
            failures++; $display("FAIL single_busy_e100 got %b want 1", busy);
        end
        step();
        checks++;
        if (busy !== 1'b0 || tx !== 1'b1) begin
            failures++; $display("FAIL single_end got busy=%b tx=%b want busy=0 tx=1", busy, tx);
        end
        checks++;
        if (rx_data.size() != 1 || rx_start.size() != 1) begin
            failures++; $display("FAIL single_rx_count got %0d want 1", rx_data.size());
        end else if (rx_data[0] !== 8'hA5 || rx_start[0] != e + 1) begin
            failures++;
            $display("FAIL single_rx got %h@%0d want a5@%0d", rx_data[0], rx_start[0], e + 1);
        end
    endtask

    task automatic test_back_to_back();
        int unsigned e;
        clear_rx();
        push(8'h00);
        e = cyc;
        push(8'hFF);
        repeat (199) step();
        checks++;
        if (busy !== 1'b1) begin
            failures++; $display("FAIL b2b_busy_e200 got %b want 1", busy);
        end
        step();
        checks++;
        if (busy !== 1'b0) begin
            failures++; $display("FAIL b2b_busy_e201 got %b want 0", busy);
        end
        checks++;
        if (rx_data.size() != 2) begin
            failures++; $display("FAIL b2b_rx_count got %0d want 2", rx_data.size());
        end else begin
            checks++;
            if (rx_data[0] !== 8'h00 || rx_data[1] !== 8'hFF) begin
                failures++;
                $display("FAIL b2b_rx_data got %h %h want 00 ff", rx_data[0], rx_data[1]);
            end
            checks++;
            if (rx_start[0] != e + 1 || rx_start[1] != e + 101) begin
                failures++;
                $display("FAIL b2b_rx_start got %0d %0d want %0d %0d",
                         rx_start[0], rx_start[1], e + 1, e + 101);
            end
            checks++;
            if (rx_stop[0] !== 1'b1 || rx_stop[1] !== 1'b1) begin
                failures++; $display("FAIL b2b_stop got %b %b want 1 1", rx_stop[0], rx_stop[1]);
            end
        end
    endtask

    task automatic test_full_fifo();
        logic [7:0]  exp [6];
        int unsigned acc [5];
        int unsigned e;
        logic        rdy;
        logic        accepted;
        int          w;
        exp = '{8'h3C, 8'h01, 8'h80, 8'h55, 8'hAA, 8'hC3};
        clear_rx();
        push(exp[0]);
        e = cyc;
        for (int i = 0; i < 5; i++) begin
            byte_data = exp[i+1];
            byte_valid = 1'b1;
            accepted = 1'b0;
            w = 0;
            while (!accepted && w < 200) begin
                rdy = byte_ready;
                step();
                w++;
                if (rdy) accepted = 1'b1;
            end
            acc[i] = cyc;
            if (i == 3) begin
                checks++;
                if (byte_ready !== 1'b0) begin
                    failures++; $display("FAIL full_ready_after4 got %b want 0", byte_ready);
                end
            end
        end
        byte_valid = 1'b0;
        checks++;
        if (acc[0] != e + 1 || acc[3] != e + 4) begin
            failures++;
            $display("FAIL full_accept_first got %0d..%0d want %0d..%0d",
                     acc[0], acc[3], e + 1, e + 4);
        end
        checks++;
        if (acc[4] != e + 102) begin
            failures++; $display("FAIL full_accept_held got %0d want %0d", acc[4], e + 102);
        end
        w = 0;
        while (rx_data.size() < 6 && w < 800) begin
            step();
            w++;
        end
        checks++;
        if (rx_data.size() != 6) begin
            failures++; $display("FAIL full_rx_count got %0d want 6", rx_data.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (rx_data[i] !== exp[i] || rx_start[i] != e + 1 + 100 * i) begin
                    failures++;
                    $display("FAIL full_frame%0d got %h@%0d want %h@%0d",
                             i, rx_data[i], rx_start[i], exp[i], e + 1 + 100 * i);
                end
            end
        end
        w = 0;
        while (busy !== 1'b0 && w < 300) begin
            step();
            w++;
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++; $display("FAIL full_busy_drain got %b want 0", busy);
        end
    endtask

    task automatic test_simultaneous();
        logic [7:0]  exp [6];
        int unsigned e;
        int          w;
        exp = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        clear_rx();
        push(exp[0]);
        e = cyc;
        push(exp[1]);
        repeat (99) step();
        push(exp[2]);
        checks++;
        if (cyc != e + 101 || byte_ready !== 1'b1) begin
            failures++;
            $display("FAIL simul_edge got cyc=%0d ready=%b want cyc=%0d ready=1",
                     cyc, byte_ready, e + 101);
        end
        push(exp[3]);
        push(exp[4]);
        checks++;
        if (byte_ready !== 1'b1) begin
            failures++; $display("FAIL simul_ready_occ3 got %b want 1", byte_ready);
        end
        push(exp[5]);
        checks++;
        if (byte_ready !== 1'b0) begin
            failures++; $display("FAIL simul_ready_occ4 got %b want 0", byte_ready);
        end
        w = 0;
        while (rx_data.size() < 6 && w < 800) begin
            step();
            w++;
        end
        checks++;
        if (rx_data.size() != 6) begin
            failures++; $display("FAIL simul_rx_count got %0d want 6", rx_data.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (rx_data[i] !== exp[i] || rx_start[i] != e + 1 + 100 * i) begin
                    failures++;
                    $display("FAIL simul_frame%0d got %h@%0d want %h@%0d",
                             i, rx_data[i], rx_start[i], exp[i], e + 1 + 100 * i);
                end
            end
        end
        w = 0;
        while (busy !== 1'b0 && w < 300) begin
            step();
            w++;
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++; $display("FAIL simul_busy_drain got %b want 0", busy);
        end
    endtask

    task automatic test_reset_mid_frame();
        int bad;
        clear_rx();
        push(8'h96);
        push(8'hC3);
        push(8'h5A);
        repeat (42) step();
        // E+44 lies inside data bit 3 of 0x96, which is 0.
        checks++;
        if (tx !== 1'b0) begin
            failures++; $display("FAIL midrst_bit3 got %b want 0", tx);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || byte_ready !== 1'b1) begin
            failures++;
            $display("FAIL midrst_state got tx=%b busy=%b ready=%b want 1 0 1",
                     tx, busy, byte_ready);
        end
        bad = 0;
        repeat (300) begin
            step();
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++; $display("FAIL midrst_quiet got %0d active cycles want 0", bad);
        end
        checks++;
        if (rx_data.size() != 0) begin
            failures++; $display("FAIL midrst_frames got %0d want 0", rx_data.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_full_fifo();
        test_simultaneous();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
